// File: rtl/hs32_mul_seq_if.sv
// Package with the shared ALU control word, plus the bus interface that
// groups the operand/result handshakes and the borrowed-ALU port of the
// hs32 shift-and-add multiplier sequencer.
package hs32_pkg;
  typedef struct packed {
    logic [1:0] opr;
    logic       neg;
    logic       sub;
    logic       cen;
    logic       fwe;
  } hs32_aluctl;
endpackage

interface hs32_mul_seq_if #(parameter int WIDTH = 32);
  import hs32_pkg::*;

  logic             flush_i;
  logic             req_valid_i;
  logic             req_ready_o;
  logic [WIDTH-1:0] req_a_i;
  logic [WIDTH-1:0] req_b_i;
  logic             resp_valid_o;
  logic             resp_ready_i;
  logic [WIDTH-1:0] resp_data_o;
  logic             alu_req_o;
  logic             alu_gnt_i;
  logic [WIDTH-1:0] alu_a_o;
  logic [WIDTH-1:0] alu_b_o;
  hs32_aluctl       alu_ctl_o;
  logic [WIDTH-1:0] alu_out_i;

  // Sequencer side
  modport slave (
    input  flush_i, req_valid_i, req_a_i, req_b_i, resp_ready_i,
           alu_gnt_i, alu_out_i,
    output req_ready_o, resp_valid_o, resp_data_o,
           alu_req_o, alu_a_o, alu_b_o, alu_ctl_o
  );

  // Pipeline / ALU-mux side
  modport master (
    output flush_i, req_valid_i, req_a_i, req_b_i, resp_ready_i,
           alu_gnt_i, alu_out_i,
    input  req_ready_o, resp_valid_o, resp_data_o,
           alu_req_o, alu_a_o, alu_b_o, alu_ctl_o
  );
endinterface

// File: rtl/hs32_mul_seq.sv
// hs32_mul_seq: multi-cycle 32x32 -> low-32 shift-and-add multiplier.
// The additions are done on the shared core ALU, which is requested only
// on iterations whose current multiplier bit is 1. All outputs are decoded
// from registered state, so there is no input-to-output combinational path.
module hs32_mul_seq
  import hs32_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic         clk,
  input  logic         reset,
  hs32_mul_seq_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_p;   // accumulator
  logic [WIDTH-1:0] r_m;   // multiplicand, shifts left
  logic [WIDTH-1:0] r_q;   // multiplier, shifts right

  logic [WIDTH-1:0] w_q_next;
  logic [WIDTH-1:0] w_m_next;
  logic             w_alu_req;
  logic             w_step;

  assign w_q_next  = {1'b0, r_q[WIDTH-1:1]};
  assign w_m_next  = {r_m[WIDTH-2:0], 1'b0};
  assign w_alu_req = (r_state == S_RUN) && r_q[0];
  // An iteration advances when no add is needed, or the add was granted.
  // A grant seen without a request is ignored by construction.
  assign w_step    = (r_state == S_RUN) && (!r_q[0] || bus.alu_gnt_i);

  assign bus.req_ready_o  = (r_state == S_IDLE);
  assign bus.resp_valid_o = (r_state == S_DONE);
  assign bus.resp_data_o  = r_p;
  assign bus.alu_req_o    = w_alu_req;
  assign bus.alu_a_o      = w_alu_req ? r_p : {WIDTH{1'b0}};
  assign bus.alu_b_o      = w_alu_req ? r_m : {WIDTH{1'b0}};
  // Plain add, no flag update, ever.
  assign bus.alu_ctl_o    = '{opr: 2'b00, neg: 1'b0, sub: 1'b0, cen: 1'b0, fwe: 1'b0};

  // Sequencer FSM and datapath registers; flush overrides every transition.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_p     <= {WIDTH{1'b0}};
      r_m     <= {WIDTH{1'b0}};
      r_q     <= {WIDTH{1'b0}};
    end else if (bus.flush_i) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.req_valid_i) begin
            r_p     <= {WIDTH{1'b0}};
            r_m     <= bus.req_a_i;
            r_q     <= bus.req_b_i;
            r_state <= (bus.req_b_i == {WIDTH{1'b0}}) ? S_DONE : S_RUN;
          end
        end
        S_RUN: begin
          if (w_step) begin
            if (r_q[0]) begin
              r_p <= bus.alu_out_i;   // carry out of the ALU is dropped
            end
            r_m <= w_m_next;
            r_q <= w_q_next;
            if (w_q_next == {WIDTH{1'b0}}) begin
              r_state <= S_DONE;
            end
          end
        end
        S_DONE: begin
          if (bus.resp_ready_i) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/hs32_mul_seq.md
# hs32_mul_seq

Multi-cycle 32×32→32 (low word) shift-and-add multiplier sequencer that borrows the shared core ALU for its additions. It accepts an operand pair over a valid/ready handshake, requests the ALU only on iterations whose multiplier bit is 1, and returns the product over a second valid/ready handshake. It sits beside the execute stage. The pipeline's ALU mux arbitrates through `alu_req_o`/`alu_gnt_i`. This block never writes the NZCV flags.

## Interface
Parameters:
- `WIDTH`, 32, operand and result width; only 32 is supported.

Ports:
- `clk`  in  1  core clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `flush_i`  in  1  synchronous abort: drop any operation in progress and return to IDLE.
- `req_valid_i`  in  1  operand pair valid.
- `req_ready_o`  out  1  sequencer can accept; high exactly in IDLE.
- `req_a_i`  in  32  multiplicand.
- `req_b_i`  in  32  multiplier.
- `resp_valid_o`  out  1  product valid; high exactly in DONE.
- `resp_ready_i`  in  1  consumer accepts the product.
- `resp_data_o`  out  32  low 32 bits of a×b; valid while `resp_valid_o` is high.
- `alu_req_o`  out  1  ALU needed this cycle.
- `alu_gnt_i`  in  1  ALU granted this cycle; the ALU output is consumed this same cycle.
- `alu_a_o`  out  32  ALU operand A = accumulator P. Zero when `alu_req_o`=0.
- `alu_b_o`  out  32  ALU operand B = shifted multiplicand M. Zero when `alu_req_o`=0.
- `alu_ctl_o`  out  hs32_aluctl  ALU control: opr=2'b00, neg=0, sub=0, cen=0, fwe=0 at all times.
- `alu_out_i`  in  32  ALU result, combinational from `alu_a_o`/`alu_b_o`.

## Operation
- Registers:
  - P: 32-bit accumulator.
  - M: 32-bit multiplicand, shifts left.
  - Q: 32-bit multiplier, shifts right.
  - state: IDLE / RUN / DONE.
- IDLE:
  - On `req_valid_i & req_ready_o`: P←0, M←`req_a_i`, Q←`req_b_i`.
  - Next state is RUN if `req_b_i`≠0, else DONE (result 0).
- RUN, Q[0]=0:
  - `alu_req_o`=0.
  - M←M<<1, Q←Q>>1.
  - If Q>>1 == 0, go to DONE.
- RUN, Q[0]=1:
  - `alu_req_o`=1.
  - If `alu_gnt_i`=1: P←`alu_out_i`, M←M<<1, Q←Q>>1, and go to DONE if Q>>1 == 0.
  - If `alu_gnt_i`=0: hold P, M, Q and state; keep requesting.
- DONE:
  - `resp_data_o`=P, `resp_valid_o`=1.
  - On `resp_ready_i`=1, go to IDLE.
  - P holds until the next accept.
- Arithmetic is modulo 2^32. Carry out of the ALU is discarded and bits shifted out of M are lost. The low word is identical for signed and unsigned operands.
- `flush_i` has priority over every transition except reset. Next state is IDLE and `alu_req_o` drops the following cycle. A response pending in DONE is discarded.
- `flush_i` and `req_valid_i` in the same IDLE cycle: the request is not accepted.
- `alu_gnt_i` while `alu_req_o`=0 is ignored.
- The sequencer is never required to release the ALU mid-iteration. Between requesting iterations it deasserts `alu_req_o` on every Q[0]=0 cycle.

## Timing
- Reset values:
  - state=IDLE; P, M, Q = 0.
  - `req_ready_o`=1, `resp_valid_o`=0, `resp_data_o`=0.
  - `alu_req_o`=0, `alu_a_o`=0, `alu_b_o`=0, `alu_ctl_o` fields all 0.
- All outputs are decoded from registered state; there are no input→output combinational paths.
- Latency with grant always high: accept edge in cycle 0, RUN in cycles 1..k, where k = floor(log2 b)+1. `resp_valid_o` rises in cycle k+1.
- If b=0, `resp_valid_o` rises in cycle 1.
- Each denied grant adds one cycle.
- Worst case is b with bit 31 set: 32 RUN cycles.
- Back-to-back operation: a request can be accepted in the cycle after the response handshake, because `req_ready_o` is high in IDLE only.
- Reset asserted mid-operation clears all state asynchronously. No response is produced and `alu_req_o` falls immediately.

## Test plan
- a=3, b=5, `alu_gnt_i`=1, `resp_ready_i`=1 → `alu_req_o` high in cycles 1 and 3 only; `resp_valid_o` in cycle 4 with `resp_data_o`=15; `req_ready_o` high again in cycle 5.
- a=3, b=5, grant withheld for the first 2 requesting cycles → `resp_valid_o` in cycle 6, `resp_data_o`=15; P/M/Q frozen while denied.
- a=0x1234, b=0 → `resp_valid_o` in cycle 1, `resp_data_o`=0, `alu_req_o` never asserted.
- a=0xFFFFFFFF, b=0xFFFFFFFF, grant always high → 32 RUN cycles, `resp_data_o`=0x00000001. Also a=0x80000000, b=2 → 0x00000000.
- `resp_ready_i` held low 5 cycles in DONE → `resp_valid_o` and `resp_data_o` stable, `req_ready_o`=0; release → IDLE next cycle.
- `flush_i` pulse in RUN cycle 2 of a=7, b=0xFF → IDLE next cycle, no response, new a=2, b=3 completes with 6. Repeat with async `reset` mid-RUN → all outputs at reset values immediately.
